// File: rtl/img_window_scanner_if.sv
// Pixel-read bus and window-stream bundle for img_window_scanner.
// slave: scanner side (drives in_addr and window outputs); master: environment side.
interface img_window_scanner_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int WIN    = 11
);
  logic                      in_valid;
  logic [ADDR_W-1:0]         in_addr;
  logic [DATA_W-1:0]         in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_W-1:0]         out_addr;
  logic [WIN*WIN*DATA_W-1:0] win_data;
  logic                      finish;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_addr, out_valid, out_addr, win_data, finish
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_addr, out_valid, out_addr, win_data, finish
  );
endinterface

// File: rtl/img_window_scanner.sv
// Raster-scan reader: fetches IMG_W x IMG_H pixels, emits interior WINxWIN windows.
// Ports: clk, rst (sync, high); io.slave = read bus (in_*) + window stream (out_*, win_data, finish).
module img_window_scanner #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int WIN    = 11
) (
  input  logic                clk,
  input  logic                rst,
  img_window_scanner_if.slave io
);
  localparam int R  = (WIN - 1) / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WB = WIN * WIN * DATA_W;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_C =
    ADDR_W'((IMG_H - 1 - R) * IMG_W + IMG_W - 1 - R);
  localparam logic [ADDR_W-1:0] OFF = ADDR_W'(R * IMG_W + R);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(2 * R);
  localparam logic [RW-1:0] R_MIN  = RW'(2 * R);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic              iss_q, iss_d;
  logic              dv_q, dv_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              ov_q, ov_d;
  logic [ADDR_W-1:0] oa_q, oa_d;
  logic [WB-1:0]     win_q, win_d;
  logic              fin_q, fin_d;

  logic [DATA_W-1:0] lb_mem [WIN-1][IMG_W];
  logic [DATA_W-1:0] colv [WIN];
  logic [DATA_W-1:0] pix;
  logic              pix_v;
  logic              advance;
  logic              wr;

  assign advance = ~(ov_q & ~io.out_ready);
  assign pix     = skid_v_q ? skid_q : io.in_data;
  assign pix_v   = skid_v_q | dv_q;

  // Column of the window entering on the right: oldest row on top.
  always_comb begin
    for (int k = 0; k < WIN; k++) colv[k] = '0;
    colv[WIN-1] = pix;
    for (int k = 0; k < WIN - 1; k++) colv[k] = lb_mem[WIN-2-k][col_q];
  end

  always_comb begin
    state_d   = state_q;
    in_addr_d = in_addr_q;
    iss_d     = iss_q;
    dv_d      = 1'b0;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    col_d     = col_q;
    row_d     = row_q;
    wa_d      = wa_q;
    ov_d      = ov_q & ~io.out_ready;
    oa_d      = oa_q;
    win_d     = win_q;
    fin_d     = fin_q;
    wr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          state_d   = RUN;
          in_addr_d = '0;
          iss_d     = 1'b0;
          skid_v_d  = 1'b0;
          col_d     = '0;
          row_d     = '0;
          wa_d      = '0;
        end
      end
      RUN, DRAIN: begin
        if (!io.in_valid) begin
          state_d   = IDLE;
          in_addr_d = '0;
          iss_d     = 1'b0;
          skid_v_d  = 1'b0;
          ov_d      = 1'b0;
          fin_d     = 1'b0;
        end else begin
          // A read only counts if the cycle advances; a stalled
          // address is simply re-read once the stall releases.
          if (state_q == RUN) begin
            if (!iss_q) begin
              iss_d = 1'b1;
            end else if (advance) begin
              dv_d = 1'b1;
              if (in_addr_q == LAST_A) begin
                iss_d   = 1'b0;
                state_d = DRAIN;
              end else begin
                in_addr_d = in_addr_q + 1'b1;
              end
            end
          end
          if (advance) begin
            skid_v_d = 1'b0;
            if (pix_v) begin
              wr = 1'b1;
              for (int dy = 0; dy < WIN; dy++) begin
                for (int dx = 0; dx < WIN - 1; dx++) begin
                  win_d[(dy*WIN+dx+1)*DATA_W-1 -: DATA_W] =
                    win_q[(dy*WIN+dx+2)*DATA_W-1 -: DATA_W];
                end
                win_d[(dy*WIN+WIN)*DATA_W-1 -: DATA_W] = colv[dy];
              end
              if (col_q == C_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
              wa_d = wa_q + 1'b1;
              if (row_q >= R_MIN && col_q >= C_MIN) begin
                ov_d = 1'b1;
                oa_d = wa_q - OFF;
              end
            end
          end else if (dv_q) begin
            skid_v_d = 1'b1;
            skid_d   = io.in_data;
          end
          if (state_q == DRAIN && ov_q && io.out_ready &&
              oa_q == LAST_C) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (!io.in_valid) begin
          state_d = IDLE;
          fin_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_addr_q <= '0;
      iss_q     <= 1'b0;
      dv_q      <= 1'b0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      wa_q      <= '0;
      ov_q      <= 1'b0;
      oa_q      <= '0;
      win_q     <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_addr_q <= in_addr_d;
      iss_q     <= iss_d;
      dv_q      <= dv_d;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wa_q      <= wa_d;
      ov_q      <= ov_d;
      oa_q      <= oa_d;
      win_q     <= win_d;
      fin_q     <= fin_d;
    end
  end

  // Line buffers, circular by column: lb_mem[0] holds the previous row.
  always_ff @(posedge clk) begin
    if (wr) begin
      lb_mem[0][col_q] <= pix;
      for (int k = 1; k < WIN - 1; k++)
        lb_mem[k][col_q] <= lb_mem[k-1][col_q];
    end
  end

  assign io.in_addr   = in_addr_q;
  assign io.out_valid = ov_q;
  assign io.out_addr  = oa_q;
  assign io.win_data  = win_q;
  assign io.finish    = fin_q;
endmodule

// File: tb/tb_img_window_scanner.sv
// Self-checking bench for img_window_scanner.
// Small 8x8/WIN=3 instance for timing/corner cases, 256x256/WIN=11 for a random image.
module tb_img_window_scanner;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int SW = 8;
  localparam int SH = 8;
  localparam int SWIN = 3;
  localparam int SR = 1;
  localparam int BW = 256;
  localparam int BH = 256;
  localparam int BWIN = 11;
  localparam int BR = 5;
  localparam int SWB = SWIN * SWIN * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  img_window_scanner_if #(.ADDR_W(AW), .DATA_W(DW), .WIN(SWIN)) s_if();
  img_window_scanner_if #(.ADDR_W(AW), .DATA_W(DW), .WIN(BWIN)) b_if();

  img_window_scanner #(
    .IMG_W(SW), .IMG_H(SH), .DATA_W(DW), .ADDR_W(AW), .WIN(SWIN)
  ) u_s (.clk(clk), .rst(rst), .io(s_if.slave));

  img_window_scanner #(
    .IMG_W(BW), .IMG_H(BH), .DATA_W(DW), .ADDR_W(AW), .WIN(BWIN)
  ) u_b (.clk(clk), .rst(rst), .io(b_if.slave));

  logic [DW-1:0] s_img [SW*SH];
  logic [DW-1:0] b_img [BW*BH];

  // Pixel memories with one cycle of read latency.
  always @(posedge clk) begin
    s_if.in_data <= s_img[s_if.in_addr[5:0]];
    b_if.in_data <= b_img[b_if.in_addr];
  end

  typedef struct {
    logic [3:0] pat;
    bit         rnd;
    int         first;
    int         last;
    int         fin;
    int         nwin;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [SWB-1:0] s_exp(input int ca);
    logic [SWB-1:0] v;
    int r, c;
    r = ca / SW;
    c = ca % SW;
    v = '0;
    for (int dy = 0; dy < SWIN; dy++)
      for (int dx = 0; dx < SWIN; dx++)
        v[(dy*SWIN+dx+1)*DW-1 -: DW] =
          s_img[(r - SR + dy) * SW + (c - SR + dx)];
    return v;
  endfunction

  task automatic s_start(output int t0);
    @(negedge clk);
    s_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic run_small(input vec_t v);
    int t0, n, nwin, first, last, fin, ea;
    int q[$];
    logic [SWB-1:0] pwin;
    logic [AW-1:0] poa, pia;
    bit pstall, done;
    for (int r = SR; r < SH - SR; r++)
      for (int c = SR; c < SW - SR; c++)
        q.push_back(r * SW + c);
    s_if.out_ready = 1'b1;
    s_start(t0);
    nwin = 0; first = -1; last = -1; fin = -1;
    pstall = 1'b0; done = 1'b0;
    pwin = '0; poa = '0; pia = '0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      n = cyc - t0;
      s_if.out_ready = v.rnd ? 1'($urandom_range(0, 1)) : v.pat[n % 4];
      if (pstall) begin
        check("stall_valid", s_if.out_valid, 1);
        check("stall_out_addr", s_if.out_addr, poa);
        check("stall_win", s_if.win_data == pwin, 1);
        check("stall_in_addr", s_if.in_addr, pia);
      end
      if (s_if.out_valid) begin
        if (first < 0) first = n;
        check("valid_with_finish", s_if.finish, 0);
      end
      if (s_if.out_valid && s_if.out_ready) begin
        nwin++;
        last = n;
        ea = (q.size() > 0) ? q.pop_front() : 'hffff;
        check("s_out_addr", s_if.out_addr, ea);
        if (ea != 'hffff)
          check("s_win_taps", s_if.win_data == s_exp(ea), 1);
      end
      pstall = s_if.out_valid & ~s_if.out_ready;
      poa = s_if.out_addr;
      pwin = s_if.win_data;
      pia = s_if.in_addr;
      if (s_if.finish) begin
        fin = n;
        done = 1'b1;
      end
    end
    check("s_timeout", done, 1);
    check("s_nwin", nwin, v.nwin);
    if (v.first >= 0) begin
      check("s_first_cycle", first, v.first);
      check("s_last_cycle", last, v.last);
      check("s_finish_cycle", fin, v.fin);
    end
  endtask

  // Hold in_valid high in DONE, then release it.
  task automatic s_done_hold();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("done_finish", s_if.finish, 1);
      check("done_valid", s_if.out_valid, 0);
    end
    s_if.in_valid = 1'b0;
    @(negedge clk);
    check("done_clear", s_if.finish, 0);
    check("done_clear_valid", s_if.out_valid, 0);
  endtask

  task automatic run_big();
    int t0, n, nwin, fin, ea;
    int q[$];
    bit done, bad;
    for (int i = 0; i < BW * BH; i++) b_img[i] = DW'($urandom);
    for (int r = BR; r < BH - BR; r++)
      for (int c = BR; c < BW - BR; c++)
        q.push_back(r * BW + c);
    b_if.out_ready = 1'b1;
    @(negedge clk);
    b_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    nwin = 0; fin = -1; done = 1'b0;
    for (int k = 0; k < 70000 && !done; k++) begin
      @(negedge clk);
      n = cyc - t0;
      if (b_if.out_valid) begin
        nwin++;
        ea = (q.size() > 0) ? q.pop_front() : 'hffff;
        check("b_out_addr", b_if.out_addr, ea);
        check("b_centre",
              b_if.win_data[(BR*BWIN+BR+1)*DW-1 -: DW],
              b_img[b_if.out_addr]);
        if (ea != 'hffff) begin
          bad = 1'b0;
          for (int dy = 0; dy < BWIN; dy++)
            for (int dx = 0; dx < BWIN; dx++)
              if (b_if.win_data[(dy*BWIN+dx+1)*DW-1 -: DW] !==
                  b_img[(ea / BW - BR + dy) * BW + (ea % BW - BR + dx)])
                bad = 1'b1;
          check("b_win_taps", bad, 0);
        end
      end
      if (b_if.finish) begin
        fin = n;
        done = 1'b1;
      end
    end
    check("b_timeout", done, 1);
    check("b_nwin", nwin, (BH - 2 * BR) * (BW - 2 * BR));
    check("b_finish_cycle", fin, BW * BH + 3);
    b_if.in_valid = 1'b0;
    @(negedge clk);
    check("b_done_clear", b_if.finish, 0);
  endtask

  initial begin
    vec_t tbl[4];
    int t0;
    bit ok, seen_fin;
    tbl[0] = '{pat: 4'b1111, rnd: 1'b0, first: 21, last: 66, fin: 67, nwin: 36};
    tbl[1] = '{pat: 4'b1001, rnd: 1'b0, first: -1, last: -1, fin: -1, nwin: 36};
    tbl[2] = '{pat: 4'b0101, rnd: 1'b0, first: -1, last: -1, fin: -1, nwin: 36};
    tbl[3] = '{pat: 4'b0000, rnd: 1'b1, first: -1, last: -1, fin: -1, nwin: 36};

    for (int i = 0; i < SW * SH; i++) s_img[i] = DW'(i);
    for (int i = 0; i < BW * BH; i++) b_img[i] = '0;
    s_if.in_valid = 1'b0;
    s_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0;
    b_if.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_valid", s_if.out_valid, 0);
    check("rst_in_addr", s_if.in_addr, 0);
    check("rst_out_addr", s_if.out_addr, 0);
    check("rst_win", s_if.win_data == '0, 1);
    check("rst_finish", s_if.finish, 0);
    check("rst_b_valid", b_if.out_valid, 0);
    check("rst_b_win", b_if.win_data == '0, 1);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_small(tbl[i]);
      s_done_hold();
    end

    // Abort by dropping in_valid at cycle 40, then a full restart.
    s_if.out_ready = 1'b1;
    s_start(t0);
    repeat (41) @(negedge clk);
    check("abort_at_cycle", cyc - t0, 40);
    s_if.in_valid = 1'b0;
    @(negedge clk);
    check("abort_valid", s_if.out_valid, 0);
    seen_fin = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (s_if.finish || s_if.out_valid) seen_fin = 1'b1;
    end
    check("abort_quiet", seen_fin, 0);
    run_small(tbl[0]);
    s_done_hold();

    // Reset pulse while a window is valid.
    s_if.out_ready = 1'b1;
    s_start(t0);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = s_if.out_valid;
    end
    check("rst_run_reach_valid", ok, 1);
    rst = 1'b1;
    s_if.in_valid = 1'b0;
    @(negedge clk);
    check("rst_run_valid", s_if.out_valid, 0);
    check("rst_run_in_addr", s_if.in_addr, 0);
    check("rst_run_finish", s_if.finish, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid", s_if.out_valid, 0);
    check("idle_in_addr", s_if.in_addr, 0);

    run_big();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
